// File: rtl/vga_pkg.sv
// Shared constants, state encoding and small helpers for the bouncing-square
// test-pattern generator.
package vga_pkg;

   localparam int H_ACT = 640;
   localparam int V_ACT = 480;

   // RGB565 palette cycled on every bounce
   localparam logic [15:0] COL_RED   = 16'hF800;
   localparam logic [15:0] COL_GREEN = 16'h07E0;
   localparam logic [15:0] COL_BLUE  = 16'h001F;
   localparam logic [15:0] COL_WHITE = 16'hFFFF;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   // Result of advancing one axis by one step
   typedef struct packed {
      logic [9:0] pos;
      logic       dir;
      logic       bounce;
   } axis_t;

   // Speed index to step size in pixels
   function automatic logic [3:0] step_px(input logic [1:0] spd);
      logic [3:0] s;
      case (spd)
         2'd0:    s = 4'd1;
         2'd1:    s = 4'd2;
         2'd2:    s = 4'd4;
         default: s = 4'd8;
      endcase
      return s;
   endfunction

   // Palette index to square colour
   function automatic logic [15:0] pal_colour(input logic [1:0] pal);
      logic [15:0] c;
      case (pal)
         2'd0:    c = COL_RED;
         2'd1:    c = COL_GREEN;
         2'd2:    c = COL_BLUE;
         default: c = COL_WHITE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// One-cycle pulse on the first cycle the controller requests the last active
// pixel of a frame. Holding that coordinate produces only one pulse.
module vga_frame_tick
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       frame_tick
);

   logic at_corner;
   logic corner_q;

   assign at_corner = (x == 10'(H_ACT - 1)) && (y == 10'(V_ACT - 1));

   // Remember last cycle's compare so only the rising edge ticks
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         corner_q <= 1'b0;
      end else begin
         corner_q <= at_corner;
      end
   end

   assign frame_tick = at_corner & ~corner_q;

endmodule

// File: rtl/vga_block_move.sv
// Bouncing-square picture source: a SIZE x SIZE square on a BG background,
// moved once per frame, with pause/run and speed controlled by key pulses.
// The colour output is registered, one cycle behind the requested coordinate.
module vga_block_move
   import vga_pkg::*;
#(
   parameter int          SIZE = 32,
   parameter logic [15:0] BG   = 16'h0000
) (
   input  logic        Clk_int,
   input  logic        Sys_Rst_n,
   input  logic [9:0]  jpg_x,
   input  logic [9:0]  jpg_y,
   input  logic [1:0]  key_down,
   output logic [15:0] jpg_colour
);

   localparam logic [9:0] LIM_X = 10'(H_ACT - SIZE);
   localparam logic [9:0] LIM_Y = 10'(V_ACT - SIZE);

   // Advance one axis by step; clamp to the wall and flip direction on contact.
   // The sum is 11 bits so pos + step cannot wrap.
   function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                       input logic [3:0] step, input logic [9:0] lim);
      axis_t       r;
      logic [10:0] sum;
      sum      = {1'b0, pos} + {7'd0, step};
      r.pos    = pos;
      r.dir    = dir;
      r.bounce = 1'b0;
      if (dir) begin
         if (sum >= {1'b0, lim}) begin
            r.pos    = lim;
            r.dir    = 1'b0;
            r.bounce = 1'b1;
         end else begin
            r.pos = sum[9:0];
         end
      end else begin
         if ({1'b0, pos} <= {7'd0, step}) begin
            r.pos    = '0;
            r.dir    = 1'b1;
            r.bounce = 1'b1;
         end else begin
            r.pos = pos - {6'd0, step};
         end
      end
      return r;
   endfunction

   state_t     state_q, state_d;
   logic [1:0] spd;
   logic [9:0] px, py;
   logic       dx, dy;
   logic [1:0] pal;
   logic       frame_tick;
   logic [3:0] step;
   axis_t      ax, ay;
   logic       move;
   logic       in_x, in_y;

   vga_frame_tick u_tick (
      .clk        (Clk_int),
      .rst_n      (Sys_Rst_n),
      .x          (jpg_x),
      .y          (jpg_y),
      .frame_tick (frame_tick)
   );

   // Next mode: key bit0 toggles run/pause
   always_comb begin
      state_d = state_q;
      if (key_down[0]) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   // Mode and speed registers; key bit1 steps speed with wrap
   always_ff @(posedge Clk_int) begin
      if (!Sys_Rst_n) begin
         state_q <= ST_RUN;
         spd     <= 2'd0;
      end else begin
         state_q <= state_d;
         if (key_down[1]) begin
            spd <= spd + 2'd1;
         end
      end
   end

   assign step = step_px(spd);
   assign ax   = axis_step(px, dx, step, LIM_X);
   assign ay   = axis_step(py, dy, step, LIM_Y);
   assign move = frame_tick && (state_q == ST_RUN);

   // Position, direction and palette update once per frame while running
   always_ff @(posedge Clk_int) begin
      if (!Sys_Rst_n) begin
         px  <= '0;
         py  <= '0;
         dx  <= 1'b1;
         dy  <= 1'b1;
         pal <= 2'd0;
      end else if (move) begin
         px <= ax.pos;
         dx <= ax.dir;
         py <= ay.pos;
         dy <= ay.dir;
         if (ax.bounce || ay.bounce) begin
            pal <= pal + 2'd1;
         end
      end
   end

   // Square membership of the requested pixel; blanking coordinates never match
   always_comb begin
      in_x = (jpg_x < 10'(H_ACT)) && (jpg_x >= px) &&
             ({1'b0, jpg_x} < ({1'b0, px} + 11'(SIZE)));
      in_y = (jpg_y < 10'(V_ACT)) && (jpg_y >= py) &&
             ({1'b0, jpg_y} < ({1'b0, py} + 11'(SIZE)));
   end

   // Registered pixel colour
   always_ff @(posedge Clk_int) begin
      if (!Sys_Rst_n) begin
         jpg_colour <= 16'h0000;
      end else begin
         jpg_colour <= (in_x && in_y) ? pal_colour(pal) : BG;
      end
   end

endmodule
